compute_ip_core: RTL and testbench

Arithmetic engine of the compute IP, directly downstream of the AXI4-Lite slave register file. The register file decodes a write to the control register into a one-cycle `start` pulse and presents operands and opcode from its slave registers. This block runs an add, subtract, sequential multiply or sequential restoring divide, then returns a 2×DATA_WIDTH result and status for the register file to expose on read-back.

---
 rtl/compute_ip_core.sv | 148 ++++++++++++++
 tb/tb_compute_ip_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/compute_ip_core.sv
// Arithmetic engine behind the AXI4-Lite register file: single-cycle ADD/SUB,
// bit-serial unsigned MUL (shift-add) and DIV (restoring), 2*DATA_WIDTH result.
module compute_ip_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [1:0]            opcode,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  div_by_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   b_reg;
  logic [CW-1:0]   cnt_reg;
  // acc_hi_reg: partial product high half (MUL) or partial remainder (DIV);
  // acc_lo_reg: multiplier shifting out LSB first (MUL) or dividend/quotient (DIV).
  logic [DW:0]     acc_hi_reg;
  logic [DW-1:0]   acc_lo_reg;

  logic [DW:0]     acc_hi_next;
  logic [DW-1:0]   acc_lo_next;
  logic [DW:0]     mul_sum;
  logic [DW:0]     mul_hi;
  logic [DW:0]     div_shift;
  logic [DW:0]     div_trial;
  logic [DW:0]     add_sum;
  logic [DW:0]     sub_diff;
  logic [DW-1:0]   fin_lo;
  logic [DW-1:0]   fin_hi;
  logic            fin_dbz;

  always_comb begin
    mul_sum     = acc_hi_reg + {1'b0, a_reg};
    mul_hi      = acc_lo_reg[0] ? mul_sum : acc_hi_reg;
    div_shift   = {acc_hi_reg[DW-1:0], acc_lo_reg[DW-1]};
    div_trial   = div_shift - {1'b0, b_reg};
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    if (op_reg == OP_MUL) begin
      acc_hi_next = {1'b0, mul_hi[DW:1]};
      acc_lo_next = {mul_hi[0], acc_lo_reg[DW-1:1]};
    end else begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      acc_hi_next = div_trial[DW] ? div_shift : div_trial;
      acc_lo_next = {acc_lo_reg[DW-2:0], ~div_trial[DW]};
    end
  end

  always_comb begin
    add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    sub_diff = {1'b0, a_reg} - {1'b0, b_reg};
    fin_lo   = acc_lo_reg;
    fin_hi   = acc_hi_reg[DW-1:0];
    fin_dbz  = 1'b0;
    case (op_reg)
      OP_ADD: begin
        fin_lo = add_sum[DW-1:0];
        fin_hi = {{(DW-1){1'b0}}, add_sum[DW]};
      end
      OP_SUB: begin
        fin_lo = sub_diff[DW-1:0];
        fin_hi = {{(DW-1){1'b0}}, sub_diff[DW]};
      end
      OP_DIV: begin
        if (b_reg == '0) begin
          fin_lo  = '1;
          fin_hi  = a_reg;
          fin_dbz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg     <= opcode;
            a_reg      <= operand_a;
            b_reg      <= operand_b;
            busy       <= 1'b1;
            cnt_reg    <= CNT_INIT;
            acc_hi_reg <= '0;
            acc_lo_reg <= (opcode == OP_MUL) ? operand_b : operand_a;
            if (opcode == OP_ADD || opcode == OP_SUB ||
                (opcode == OP_DIV && operand_b == '0))
              state_reg <= FIN;
            else
              state_reg <= ITER;
          end
        end
        ITER: begin
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          cnt_reg    <= cnt_reg - CW'(1);
          if (cnt_reg == '0)
            state_reg <= FIN;
        end
        FIN: begin
          result_lo   <= fin_lo;
          result_hi   <= fin_hi;
          div_by_zero <= fin_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_ip_core.sv
// Self-checking bench for compute_ip_core: vector table, random ops against a
// behavioural model, and hand-written reset / busy / back-to-back sequences.
module tb_compute_ip_core;

  localparam int DW = 32;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    opcode;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic          busy;
  logic          done;
  logic [DW-1:0] result_lo;
  logic [DW-1:0] result_hi;
  logic          div_by_zero;

  always #5 clk = ~clk;

  compute_ip_core #(.DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          dbz;
    int            lat;   // edges after the edge that samples start
  } vec_t;

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          dbz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 lo=%0h hi=%0h, expected no done", result_lo, result_hi);
      end else begin
        e = sb.pop_front();
        $display("txn done: lo=%08h hi=%08h dbz=%0b", result_lo, result_hi, div_by_zero);
        check("result_lo", result_lo, e.lo);
        check("result_hi", result_hi, e.hi);
        check("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  // Drive a start pulse; returns 1 time unit after the sampling edge T0.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] lo, input logic [DW-1:0] hi, input logic dbz);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; operand_a = a; operand_b = b;
    e.lo = lo; e.hi = hi; e.dbz = dbz;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done; returns at the falling edge inside the done cycle.
  task automatic wait_done(input string name, input int exp_lat, input int edges0, input int busy0);
    int edges = edges0;
    int busy_cnt = busy0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      if (edges >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got no done after %0d edges, expected done at %0d", name, edges, exp_lat);
        sb.delete();
        return;
      end
      @(posedge clk);
      edges++;
    end
    check({name, "_latency"}, edges, exp_lat);
    check({name, "_busy_cycles"}, busy_cnt, exp_lat);
    check({name, "_busy_low_in_done"}, busy, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    vec_t v;
    logic [63:0] p;
    logic [32:0] s;

    vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h1, 1'b0, 1};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h1, 1'b0, 1};
    vecs[2]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[3]  = '{OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
    vecs[4]  = '{OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1};
    vecs[5]  = '{OP_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1};
    vecs[6]  = '{OP_SUB, 32'd7, 32'd5, 32'd2, 32'h0, 1'b0, 1};
    vecs[7]  = '{OP_MUL, 32'h12345678, 32'h10, 32'h23456780, 32'h1, 1'b0, 33};
    vecs[8]  = '{OP_DIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 33};
    vecs[9]  = '{OP_DIV, 32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 33};
    vecs[10] = '{OP_MUL, 32'h0, 32'd5, 32'h0, 32'h0, 1'b0, 33};
    vecs[11] = '{OP_SUB, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1};

    rst_n = 1'b0; start = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", {result_hi, result_lo}, 64'h0);
    check("reset_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      issue(v.op, v.a, v.b, v.lo, v.hi, v.dbz);
      wait_done($sformatf("vec%0d", i), v.lat, 0, 0);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_hold", i), {div_by_zero, result_hi, result_lo}, {v.dbz, v.hi, v.lo});
    end

    // Random operations against a plain-arithmetic model
    for (int i = 0; i < 8; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a = $urandom;
      v.b = (i == 5) ? 32'h0 : ((v.op == OP_DIV) ? 32'($urandom_range(1, 100000)) : $urandom);
      v.dbz = 1'b0;
      v.lat = 33;
      case (v.op)
        OP_ADD: begin s = {1'b0, v.a} + {1'b0, v.b}; v.lo = s[31:0]; v.hi = {31'h0, s[32]}; v.lat = 1; end
        OP_SUB: begin v.lo = v.a - v.b; v.hi = (v.a < v.b) ? 32'h1 : 32'h0; v.lat = 1; end
        OP_MUL: begin p = 64'(v.a) * 64'(v.b); v.lo = p[31:0]; v.hi = p[63:32]; end
        default: begin
          if (v.b == 0) begin v.lo = '1; v.hi = v.a; v.dbz = 1'b1; v.lat = 1; end
          else begin v.lo = v.a / v.b; v.hi = v.a % v.b; end
        end
      endcase
      issue(v.op, v.a, v.b, v.lo, v.hi, v.dbz);
      wait_done($sformatf("rnd%0d", i), v.lat, 0, 0);
    end

    // Asynchronous reset in the middle of a multiply
    issue(OP_MUL, 32'd7, 32'd9, 32'd63, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", {result_hi, result_lo}, 64'h0);
    check("abort_dbz", div_by_zero, 1'b0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(OP_ADD, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0);
    wait_done("post_reset_add", 1, 0, 0);

    // start while busy must be ignored
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; opcode = OP_ADD; operand_a = 32'd100; operand_b = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_restart", 33, 5, 5);
    repeat (40) @(negedge clk);

    // Back-to-back: ADD requested during the done cycle of a MUL
    issue(OP_MUL, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);
    wait_done("b2b_mul", 33, 0, 0);
    start = 1'b1; opcode = OP_ADD; operand_a = 32'd1; operand_b = 32'd1;
    begin
      exp_t e;
      e.lo = 32'd2; e.hi = 32'd0; e.dbz = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1 start = 1'b0;
    check("b2b_busy_after_t0", busy, 1'b1);
    check("b2b_hold_lo", result_lo, 32'd42);
    wait_done("b2b_add", 1, 0, 0);
    repeat (5) @(negedge clk);
    check("b2b_final_hold", result_lo, 32'd2);
    check("b2b_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
